// File: rtl/fx3_cmd_parser.sv
// -----------------------------------------------------------------------------
// fx3_cmd_parser
//
// Parses command packets read from the FX3 slave FIFO command endpoint and
// atomically updates the capture configuration used by the write path and the
// channel mux.
//
// Packet (one contiguous rd_valid run, word index from 0):
//   0 : HEADER
//   1 : packets_to_send
//   2 : ch_src[3..0]  (byte 0 = ch_src[0])
//   3 : ch_src[7..4]  (byte 0 = ch_src[4])
//   4 : LED pattern in bits [3:0]
//   5 : checksum = w1 ^ w2 ^ w3 ^ w4
//   further words are ignored
//
// Ports:
//   clk_pll          system clock, sole clock
//   reset            synchronous active-high reset
//   rd_valid         read word strobe; a packet is one high run
//   rd_data   [31:0] read word
//   cfg_hold         write sequencer mid-burst; defers commit
//   packets_to_send  committed burst count (16 KiB units)
//   ch_src_flat      committed sources, ch_src[i] = bits [8i+7:8i]
//   user_led  [3:0]  committed LED bits (raw)
//   cfg_update       one-cycle pulse on each commit
//   busy             high whenever the parser is not idle
//   cmd_ok_cnt       saturating count of committed packets
//   cmd_err_cnt      saturating count of rejected packets
//   last_err  [1:0]  most recent rejection: 0 none, 1 header, 2 short, 3 csum
// -----------------------------------------------------------------------------
module fx3_cmd_parser #(
    parameter logic [31:0] HEADER      = 32'hCAFEB0BA,
    parameter int          SRC_MAX     = 12,
    parameter int          SRC_DEFAULT = 8
) (
    input  logic        clk_pll,
    input  logic        reset,
    input  logic        rd_valid,
    input  logic [31:0] rd_data,
    input  logic        cfg_hold,
    output logic [31:0] packets_to_send,
    output logic [63:0] ch_src_flat,
    output logic [3:0]  user_led,
    output logic        cfg_update,
    output logic        busy,
    output logic [15:0] cmd_ok_cnt,
    output logic [15:0] cmd_err_cnt,
    output logic [1:0]  last_err
);

    localparam logic [7:0]  SRC_MAX_B     = 8'(SRC_MAX);
    localparam logic [7:0]  SRC_DEFAULT_B = 8'(SRC_DEFAULT);
    localparam logic [63:0] SRC_RESET     = {8{SRC_DEFAULT_B}};
    localparam logic [2:0]  IDX_CSUM      = 3'd5;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_HEADER = 2'd1;
    localparam logic [1:0] ERR_SHORT  = 2'd2;
    localparam logic [1:0] ERR_CSUM   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BODY,
        S_PEND,
        S_DRAIN
    } state_t;

    state_t      state_reg, state_next;
    logic [2:0]  idx_reg, idx_next;
    logic [31:0] csum_reg, csum_next;

    // Shadow copy of the packet under construction.
    logic [31:0] pkt_shadow_reg, pkt_shadow_next;
    logic [63:0] src_shadow_reg, src_shadow_next;
    logic [3:0]  led_shadow_reg, led_shadow_next;

    // Committed configuration.
    logic [31:0] pkt_reg, pkt_next;
    logic [63:0] src_reg, src_next;
    logic [3:0]  led_reg, led_next;
    logic        cfg_update_reg, cfg_update_next;

    logic [15:0] ok_cnt_reg, ok_cnt_next;
    logic [15:0] err_cnt_reg, err_cnt_next;
    logic [1:0]  last_err_reg, last_err_next;

    logic        commit;
    logic        reject;
    logic [1:0]  reject_code;

    // Source bytes are clamped as they are loaded so the shadow always holds
    // a legal index; the checksum still covers the raw word.
    logic [31:0] word_clamped;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_clamp
            assign word_clamped[8*gi +: 8] =
                (rd_data[8*gi +: 8] > SRC_MAX_B) ? SRC_DEFAULT_B : rd_data[8*gi +: 8];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Next-state / datapath
    // -------------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        csum_next       = csum_reg;
        pkt_shadow_next = pkt_shadow_reg;
        src_shadow_next = src_shadow_reg;
        led_shadow_next = led_shadow_reg;
        commit          = 1'b0;
        reject          = 1'b0;
        reject_code     = ERR_NONE;

        unique case (state_reg)
            S_IDLE: begin
                if (rd_valid) begin
                    if (rd_data == HEADER) begin
                        state_next = S_BODY;
                        idx_next   = 3'd1;
                        csum_next  = 32'd0;
                    end else begin
                        state_next  = S_DRAIN;
                        reject      = 1'b1;
                        reject_code = ERR_HEADER;
                    end
                end
            end

            S_BODY: begin
                if (!rd_valid) begin
                    state_next  = S_IDLE;
                    reject      = 1'b1;
                    reject_code = ERR_SHORT;
                end else if (idx_reg != IDX_CSUM) begin
                    case (idx_reg)
                        3'd1:    pkt_shadow_next        = rd_data;
                        3'd2:    src_shadow_next[31:0]  = word_clamped;
                        3'd3:    src_shadow_next[63:32] = word_clamped;
                        default: led_shadow_next        = rd_data[3:0];
                    endcase
                    csum_next = csum_reg ^ rd_data;
                    idx_next  = idx_reg + 3'd1;
                end else if (rd_data != csum_reg) begin
                    state_next  = S_DRAIN;
                    reject      = 1'b1;
                    reject_code = ERR_CSUM;
                end else if (!cfg_hold) begin
                    commit     = 1'b1;
                    state_next = S_DRAIN;
                end else begin
                    state_next = S_PEND;
                end
            end

            S_PEND: begin
                // The packet is already validated; trailing words are dropped
                // and the commit waits for the write sequencer to go idle.
                if (!cfg_hold) begin
                    commit     = 1'b1;
                    state_next = rd_valid ? S_DRAIN : S_IDLE;
                end
            end

            default: begin // S_DRAIN
                if (!rd_valid) begin
                    state_next = S_IDLE;
                end
            end
        endcase
    end

    // Commit and bookkeeping.
    always_comb begin
        pkt_next        = pkt_reg;
        src_next        = src_reg;
        led_next        = led_reg;
        cfg_update_next = 1'b0;
        ok_cnt_next     = ok_cnt_reg;
        err_cnt_next    = err_cnt_reg;
        last_err_next   = last_err_reg;

        if (commit) begin
            pkt_next        = pkt_shadow_reg;
            src_next        = src_shadow_reg;
            led_next        = led_shadow_reg;
            cfg_update_next = 1'b1;
            if (ok_cnt_reg != 16'hFFFF) begin
                ok_cnt_next = ok_cnt_reg + 16'd1;
            end
        end

        if (reject) begin
            last_err_next = reject_code;
            if (err_cnt_reg != 16'hFFFF) begin
                err_cnt_next = err_cnt_reg + 16'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_pll) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            idx_reg        <= 3'd0;
            csum_reg       <= 32'd0;
            pkt_shadow_reg <= 32'd0;
            src_shadow_reg <= 64'd0;
            led_shadow_reg <= 4'd0;
            pkt_reg        <= 32'd0;
            src_reg        <= SRC_RESET;
            led_reg        <= 4'd0;
            cfg_update_reg <= 1'b0;
            ok_cnt_reg     <= 16'd0;
            err_cnt_reg    <= 16'd0;
            last_err_reg   <= ERR_NONE;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            csum_reg       <= csum_next;
            pkt_shadow_reg <= pkt_shadow_next;
            src_shadow_reg <= src_shadow_next;
            led_shadow_reg <= led_shadow_next;
            pkt_reg        <= pkt_next;
            src_reg        <= src_next;
            led_reg        <= led_next;
            cfg_update_reg <= cfg_update_next;
            ok_cnt_reg     <= ok_cnt_next;
            err_cnt_reg    <= err_cnt_next;
            last_err_reg   <= last_err_next;
        end
    end

    assign packets_to_send = pkt_reg;
    assign ch_src_flat     = src_reg;
    assign user_led        = led_reg;
    assign cfg_update      = cfg_update_reg;
    assign busy            = (state_reg != S_IDLE);
    assign cmd_ok_cnt      = ok_cnt_reg;
    assign cmd_err_cnt     = err_cnt_reg;
    assign last_err        = last_err_reg;

endmodule

// File: tb/tb_fx3_cmd_parser.sv
// -----------------------------------------------------------------------------
// tb_fx3_cmd_parser
//
// Table-driven bench for fx3_cmd_parser. Each table row is one clock of
// stimulus plus the outputs expected just after that edge. Hold, reset and
// counter-saturation behaviour are exercised by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_fx3_cmd_parser;

    localparam logic [63:0] SRC_RST = 64'h0808080808080808;
    localparam logic [63:0] SRC_A   = 64'h080B0A09_03020100;
    localparam logic [63:0] SRC_B   = 64'h00000004_0C080807;

    logic        clk_pll = 1'b0;
    logic        reset;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        cfg_hold;
    logic [31:0] packets_to_send;
    logic [63:0] ch_src_flat;
    logic [3:0]  user_led;
    logic        cfg_update;
    logic        busy;
    logic [15:0] cmd_ok_cnt;
    logic [15:0] cmd_err_cnt;
    logic [1:0]  last_err;

    int checks = 0;
    int errors = 0;

    always #5 clk_pll = ~clk_pll;

    fx3_cmd_parser dut (
        .clk_pll         (clk_pll),
        .reset           (reset),
        .rd_valid        (rd_valid),
        .rd_data         (rd_data),
        .cfg_hold        (cfg_hold),
        .packets_to_send (packets_to_send),
        .ch_src_flat     (ch_src_flat),
        .user_led        (user_led),
        .cfg_update      (cfg_update),
        .busy            (busy),
        .cmd_ok_cnt      (cmd_ok_cnt),
        .cmd_err_cnt     (cmd_err_cnt),
        .last_err        (last_err)
    );

    // cfg selects the expected committed configuration: 0 reset, 1 A, 2 B.
    typedef struct {
        logic        valid;
        logic [31:0] data;
        logic        hold;
        logic        busy;
        logic        upd;
        int          cfg;
        logic [15:0] ok;
        logic [15:0] err;
        logic [1:0]  last;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [31:0] d, input logic h,
                       input logic b, input logic u, input int c,
                       input logic [15:0] ok, input logic [15:0] err,
                       input logic [1:0] last);
        vec_t t;
        t.valid = v; t.data = d; t.hold = h; t.busy = b; t.upd = u;
        t.cfg = c; t.ok = ok; t.err = err; t.last = last;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic b, input logic u,
                                 input int c, input logic [15:0] ok,
                                 input logic [15:0] err, input logic [1:0] last);
        logic [31:0] e_pkt;
        logic [63:0] e_src;
        logic [3:0]  e_led;
        int          err_before;
        err_before = errors;
        case (c)
            1:       begin e_pkt = 32'd3; e_src = SRC_A;   e_led = 4'h5; end
            2:       begin e_pkt = 32'd7; e_src = SRC_B;   e_led = 4'hA; end
            default: begin e_pkt = 32'd0; e_src = SRC_RST; e_led = 4'h0; end
        endcase
        chk({tag, ".packets_to_send"}, 64'(packets_to_send), 64'(e_pkt));
        chk({tag, ".ch_src_flat"},     ch_src_flat,          e_src);
        chk({tag, ".user_led"},        64'(user_led),        64'(e_led));
        chk({tag, ".cfg_update"},      64'(cfg_update),      64'(u));
        chk({tag, ".busy"},            64'(busy),            64'(b));
        chk({tag, ".cmd_ok_cnt"},      64'(cmd_ok_cnt),      64'(ok));
        chk({tag, ".cmd_err_cnt"},     64'(cmd_err_cnt),     64'(err));
        chk({tag, ".last_err"},        64'(last_err),        64'(last));
        $display("%s: valid=%0b data=%h hold=%0b busy=%0b upd=%0b pkt=%0d ok=%0d err=%0d last=%0d %s",
                 tag, rd_valid, rd_data, cfg_hold, busy, cfg_update, packets_to_send,
                 cmd_ok_cnt, cmd_err_cnt, last_err, (errors == err_before) ? "ok" : "bad");
    endtask

    // Drive one word and advance past the next rising edge.
    task automatic apply(input logic v, input logic [31:0] d, input logic h);
        rd_valid = v;
        rd_data  = d;
        cfg_hold = h;
        @(posedge clk_pll);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        rd_valid = 1'b0;
        rd_data  = 32'd0;
        cfg_hold = 1'b0;
        repeat (3) @(posedge clk_pll);
        #1;
        check_outputs("reset_hold", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        apply(0, 32'd0, 0);
        check_outputs("reset_idle", 0, 0, 0, 0, 0, 0);

        // Valid packet A, commit visible right after the checksum word.
        add(1, 32'hCAFEB0BA, 0, 1, 0, 0, 0, 0, 0);
        add(1, 32'h00000003, 0, 1, 0, 0, 0, 0, 0);
        add(1, 32'h03020100, 0, 1, 0, 0, 0, 0, 0);
        add(1, 32'hFF0B0A09, 0, 1, 0, 0, 0, 0, 0);
        add(1, 32'h00000005, 0, 1, 0, 0, 0, 0, 0);
        add(1, 32'hFC090B0F, 0, 1, 1, 1, 1, 0, 0);
        add(0, 32'h00000000, 0, 0, 0, 1, 1, 0, 0);
        // Packet A with a bad checksum, then valid packet B.
        add(1, 32'hCAFEB0BA, 0, 1, 0, 1, 1, 0, 0);
        add(1, 32'h00000003, 0, 1, 0, 1, 1, 0, 0);
        add(1, 32'h03020100, 0, 1, 0, 1, 1, 0, 0);
        add(1, 32'hFF0B0A09, 0, 1, 0, 1, 1, 0, 0);
        add(1, 32'h00000005, 0, 1, 0, 1, 1, 0, 0);
        add(1, 32'hFC090B0E, 0, 1, 0, 1, 1, 1, 3);
        add(0, 32'h00000000, 0, 0, 0, 1, 1, 1, 3);
        add(1, 32'hCAFEB0BA, 0, 1, 0, 1, 1, 1, 3);
        add(1, 32'h00000007, 0, 1, 0, 1, 1, 1, 3);
        add(1, 32'h0C0D0807, 0, 1, 0, 1, 1, 1, 3);
        add(1, 32'h00000004, 0, 1, 0, 1, 1, 1, 3);
        add(1, 32'hFFFFFFFA, 0, 1, 0, 1, 1, 1, 3);
        add(1, 32'hF3F2F7FE, 0, 1, 1, 2, 2, 1, 3);
        add(0, 32'h00000000, 0, 0, 0, 2, 2, 1, 3);
        // Bad header; trailing words, including a HEADER, are ignored.
        add(1, 32'hDEADBEEF, 0, 1, 0, 2, 2, 2, 1);
        add(1, 32'hCAFEB0BA, 0, 1, 0, 2, 2, 2, 1);
        add(1, 32'h00000003, 0, 1, 0, 2, 2, 2, 1);
        add(1, 32'h03020100, 0, 1, 0, 2, 2, 2, 1);
        add(1, 32'hFF0B0A09, 0, 1, 0, 2, 2, 2, 1);
        add(1, 32'h00000005, 0, 1, 0, 2, 2, 2, 1);
        add(0, 32'h00000000, 0, 0, 0, 2, 2, 2, 1);
        // Short packet: rd_valid drops after word 3.
        add(1, 32'hCAFEB0BA, 0, 1, 0, 2, 2, 2, 1);
        add(1, 32'h00000003, 0, 1, 0, 2, 2, 2, 1);
        add(1, 32'h03020100, 0, 1, 0, 2, 2, 2, 1);
        add(1, 32'hFF0B0A09, 0, 1, 0, 2, 2, 2, 1);
        add(0, 32'h00000000, 0, 0, 0, 2, 2, 3, 2);
        add(0, 32'h00000000, 0, 0, 0, 2, 2, 3, 2);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].valid, vecs[i].data, vecs[i].hold);
            check_outputs($sformatf("vec%0d", i), vecs[i].busy, vecs[i].upd,
                          vecs[i].cfg, vecs[i].ok, vecs[i].err, vecs[i].last);
        end

        // Commit deferred by cfg_hold.
        apply(1, 32'hCAFEB0BA, 0);
        apply(1, 32'h00000003, 0);
        apply(1, 32'h03020100, 0);
        apply(1, 32'hFF0B0A09, 0);
        apply(1, 32'h00000005, 0);
        apply(1, 32'hFC090B0F, 1);
        check_outputs("hold_w5", 1, 0, 2, 2, 3, 2);
        for (int i = 0; i < 10; i++) begin
            apply(0, 32'd0, 1);
            check_outputs($sformatf("hold%0d", i), 1, 0, 2, 2, 3, 2);
        end
        apply(0, 32'd0, 0);
        check_outputs("hold_commit", 0, 1, 1, 3, 3, 2);
        for (int i = 0; i < 3; i++) begin
            apply(0, 32'd0, 0);
            check_outputs($sformatf("hold_after%0d", i), 0, 0, 1, 3, 3, 2);
        end

        // Reset mid-packet (at word 3) of a valid packet B.
        apply(1, 32'hCAFEB0BA, 0);
        apply(1, 32'h00000007, 0);
        apply(1, 32'h0C0D0807, 0);
        reset = 1'b1;
        apply(1, 32'h00000004, 0);
        check_outputs("rst_mid", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            apply(0, 32'd0, 0);
            check_outputs($sformatf("rst_after%0d", i), 0, 0, 0, 0, 0, 0);
        end

        // Error counter saturation.
        @(negedge clk_pll);
        force dut.err_cnt_reg = 16'hFFFF;
        @(posedge clk_pll);
        #1;
        release dut.err_cnt_reg;
        apply(0, 32'd0, 0);
        check_outputs("sat_preset", 0, 0, 0, 0, 16'hFFFF, 0);
        apply(1, 32'hDEADBEEF, 0);
        check_outputs("sat_bad", 1, 0, 0, 0, 16'hFFFF, 1);
        apply(0, 32'd0, 0);
        check_outputs("sat_idle", 0, 0, 0, 0, 16'hFFFF, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
